n64_sdram_arbiter: RTL and testbench

Two-requester arbiter for the single SDRAM controller port, between the N64 PI bus (latency-critical) and USB DMA. Sits between the N64 bus fabric / USB DMA engine and the SDRAM command controller. It grants one request at a time, registers the winning command, and routes the controller acknowledge and read data back to the owner. N64 has fixed priority; an optional starvation guard bounds DMA wait.

---
 rtl/n64_sdram_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_n64_sdram_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/n64_sdram_arbiter.sv
// n64_sdram_arbiter
//
// Shares the single SDRAM controller command port between the N64 PI bus
// (latency-critical, fixed priority) and the USB DMA engine. One request is
// granted at a time: the winner's command is registered onto mem_*, the
// controller acknowledge is awaited, and the ack plus read data are routed
// back to the owner as a one-cycle pulse.
//
// Build option: SDRAM_ARB_STARVE_GUARD_EN
//   defined     - a 4-bit streak counter forces a DMA grant after STARVE_MAX
//                 consecutive N64 grants made while DMA was waiting.
//   not defined - strict N64 priority; DMA may wait indefinitely.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   n64_req/write/address/wdata  N64 command (held until n64_ack)
//   n64_ack, n64_rdata           N64 completion pulse and read data
//   dma_req/write/address/wdata  DMA command (held until dma_ack)
//   dma_ack, dma_rdata           DMA completion pulse and read data
//   mem_req/write/address/wdata  registered command to SDRAM controller
//   mem_ack, mem_rdata           controller completion pulse and read data
//
// Every output is driven straight from a register.

module n64_sdram_arbiter #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              n64_req,
    input  logic              n64_write,
    input  logic [ADDR_W-1:0] n64_address,
    input  logic [DATA_W-1:0] n64_wdata,
    output logic              n64_ack,
    output logic [DATA_W-1:0] n64_rdata,
    input  logic              dma_req,
    input  logic              dma_write,
    input  logic [ADDR_W-1:0] dma_address,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_req,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_N64 = 2'd1, OWN_DMA = 2'd2} owner_t;

    state_t              state_r, state_next_s;
    owner_t              owner_r, owner_next_s;
    logic                mem_req_r, mem_req_next_s;
    logic                mem_write_r, mem_write_next_s;
    logic [ADDR_W-1:0]   mem_address_r, mem_address_next_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_next_s;
    logic                n64_ack_r, n64_ack_next_s;
    logic                dma_ack_r, dma_ack_next_s;
    logic [DATA_W-1:0]   n64_rdata_r, n64_rdata_next_s;
    logic [DATA_W-1:0]   dma_rdata_r, dma_rdata_next_s;
    logic                forced_s;
    logic                grant_n64_s;
    logic                grant_dma_s;

`ifdef SDRAM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STREAK_LIMIT = 4'(STARVE_MAX);
    logic [3:0] streak_r, streak_next_s;

    // DMA is forced through once N64 has won STARVE_MAX times in a row over it.
    assign forced_s = (streak_r == STREAK_LIMIT) && dma_req;
`else
    // Strict priority: DMA is never forced ahead of N64.
    assign forced_s = 1'b0;
`endif

    assign grant_n64_s = n64_req && !forced_s;
    assign grant_dma_s = !grant_n64_s && dma_req;

    // Next-state, datapath and output computation.
    always_comb begin
        state_next_s       = state_r;
        owner_next_s       = owner_r;
        mem_req_next_s     = mem_req_r;
        mem_write_next_s   = mem_write_r;
        mem_address_next_s = mem_address_r;
        mem_wdata_next_s   = mem_wdata_r;
        n64_ack_next_s     = 1'b0;
        dma_ack_next_s     = 1'b0;
        n64_rdata_next_s   = n64_rdata_r;
        dma_rdata_next_s   = dma_rdata_r;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
        streak_next_s      = streak_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (grant_n64_s) begin
                    owner_next_s       = OWN_N64;
                    mem_req_next_s     = 1'b1;
                    mem_write_next_s   = n64_write;
                    mem_address_next_s = n64_address;
                    mem_wdata_next_s   = n64_wdata;
                    state_next_s       = ST_ACCESS;
                end else if (grant_dma_s) begin
                    owner_next_s       = OWN_DMA;
                    mem_req_next_s     = 1'b1;
                    mem_write_next_s   = dma_write;
                    mem_address_next_s = dma_address;
                    mem_wdata_next_s   = dma_wdata;
                    state_next_s       = ST_ACCESS;
                end else begin
                    state_next_s       = ST_IDLE;
                end
`ifdef SDRAM_ARB_STARVE_GUARD_EN
                // Streak only counts N64 wins that actually made DMA wait.
                if (!dma_req || grant_dma_s) begin
                    streak_next_s = 4'd0;
                end else if (grant_n64_s && (streak_r < STREAK_LIMIT)) begin
                    streak_next_s = streak_r + 4'd1;
                end else begin
                    streak_next_s = streak_r;
                end
`endif
            end
            ST_ACCESS: begin
                // Owner's req is not rechecked: a dropped request still completes.
                if (mem_ack) begin
                    mem_req_next_s = 1'b0;
                    state_next_s   = ST_RESP;
                    if (owner_r == OWN_N64) begin
                        n64_rdata_next_s = mem_rdata;
                        n64_ack_next_s   = 1'b1;
                    end else begin
                        dma_rdata_next_s = mem_rdata;
                        dma_ack_next_s   = 1'b1;
                    end
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                owner_next_s = OWN_NONE;
                state_next_s = ST_IDLE;
            end
            default: begin
                owner_next_s   = OWN_NONE;
                mem_req_next_s = 1'b0;
                state_next_s   = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            owner_r       <= OWN_NONE;
            mem_req_r     <= 1'b0;
            mem_write_r   <= 1'b0;
            mem_address_r <= {ADDR_W{1'b0}};
            mem_wdata_r   <= {DATA_W{1'b0}};
            n64_ack_r     <= 1'b0;
            dma_ack_r     <= 1'b0;
            n64_rdata_r   <= {DATA_W{1'b0}};
            dma_rdata_r   <= {DATA_W{1'b0}};
        end else begin
            state_r       <= state_next_s;
            owner_r       <= owner_next_s;
            mem_req_r     <= mem_req_next_s;
            mem_write_r   <= mem_write_next_s;
            mem_address_r <= mem_address_next_s;
            mem_wdata_r   <= mem_wdata_next_s;
            n64_ack_r     <= n64_ack_next_s;
            dma_ack_r     <= dma_ack_next_s;
            n64_rdata_r   <= n64_rdata_next_s;
            dma_rdata_r   <= dma_rdata_next_s;
        end
    end

`ifdef SDRAM_ARB_STARVE_GUARD_EN
    // Starvation streak counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak_r <= 4'd0;
        end else begin
            streak_r <= streak_next_s;
        end
    end
`endif

    assign mem_req     = mem_req_r;
    assign mem_write   = mem_write_r;
    assign mem_address = mem_address_r;
    assign mem_wdata   = mem_wdata_r;
    assign n64_ack     = n64_ack_r;
    assign dma_ack     = dma_ack_r;
    assign n64_rdata   = n64_rdata_r;
    assign dma_rdata   = dma_rdata_r;

endmodule

// File: tb/tb_n64_sdram_arbiter.sv
// Testbench for n64_sdram_arbiter: cycle vector table plus hand-written
// sequences for priority/starvation and asynchronous reset.
module tb_n64_sdram_arbiter;

    localparam int AW = 26;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          n64_req = 1'b0, n64_write = 1'b0;
    logic [AW-1:0] n64_address = '0;
    logic [DW-1:0] n64_wdata = '0;
    logic          n64_ack;
    logic [DW-1:0] n64_rdata;
    logic          dma_req = 1'b0, dma_write = 1'b0;
    logic [AW-1:0] dma_address = '0;
    logic [DW-1:0] dma_wdata = '0;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;
    logic          mem_req, mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int tests = 0;
    int fails = 0;

    n64_sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .n64_req(n64_req), .n64_write(n64_write), .n64_address(n64_address),
        .n64_wdata(n64_wdata), .n64_ack(n64_ack), .n64_rdata(n64_rdata),
        .dma_req(dma_req), .dma_write(dma_write), .dma_address(dma_address),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_req(mem_req), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          n_req;
        logic          n_wr;
        logic [AW-1:0] n_addr;
        logic [DW-1:0] n_wd;
        logic          d_req;
        logic          d_wr;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wd;
        logic          m_ack;
        logic [DW-1:0] m_rd;
        logic          e_req;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic          e_nack;
        logic          e_dack;
        logic [DW-1:0] e_nrd;
        logic [DW-1:0] e_drd;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, "_mem_address"}, 32'(mem_address), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_n64_ack"}, 32'(n64_ack), 32'd0);
        chk({tag, "_dma_ack"}, 32'(dma_ack), 32'd0);
        chk({tag, "_n64_rdata"}, 32'(n64_rdata), 32'd0);
        chk({tag, "_dma_rdata"}, 32'(dma_rdata), 32'd0);
    endtask

    // Waits (bounded) for mem_req, returns granted address, pulses mem_ack
    // and checks the matching owner ack one cycle later.
    task automatic serve(input logic [DW-1:0] rd, output logic [AW-1:0] addr);
        int cnt = 0;
        while (!mem_req && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        if (!mem_req) begin
            chk("grant_timeout", 32'd0, 32'd1);
            addr = '0;
        end else begin
            addr = mem_address;
            mem_ack = 1'b1;
            mem_rdata = rd;
            @(negedge clk);
            mem_ack = 1'b0;
            if (addr == 26'h10) chk("serve_n64_ack", 32'(n64_ack), 32'd1);
            else chk("serve_dma_ack", 32'(dma_ack), 32'd1);
        end
    endtask

    initial begin
        logic [AW-1:0] got;
        logic [AW-1:0] exp_addr;
        int ack_seen;

        //            n_req n_wr  n_addr    n_wd      d_req d_wr  d_addr    d_wd      m_ack m_rd      | e_req e_wr e_addr    e_wd      nack  dack  nrd       drd
        vecs[0]  = '{1'b1, 1'b0, 26'h1234, 16'h0000, 1'b0, 1'b0, 26'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 26'h1234, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 26'h1234, 16'h0000, 1'b0, 1'b0, 26'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 26'h1234, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b1, 1'b0, 26'h1234, 16'h0000, 1'b0, 1'b0, 26'h0000, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0, 26'h1234, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 16'h0000};
        vecs[3]  = '{1'b1, 1'b0, 26'h1234, 16'h0000, 1'b0, 1'b0, 26'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 26'h1234, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
        vecs[4]  = '{1'b0, 1'b0, 26'h0000, 16'h0000, 1'b0, 1'b0, 26'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 26'h1234, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
        vecs[5]  = '{1'b1, 1'b1, 26'h0010, 16'hA5A5, 1'b1, 1'b0, 26'h0020, 16'h5555, 1'b0, 16'h0000, 1'b1, 1'b1, 26'h0010, 16'hA5A5, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
        vecs[6]  = '{1'b1, 1'b1, 26'h0010, 16'hA5A5, 1'b1, 1'b0, 26'h0020, 16'h5555, 1'b1, 16'h1111, 1'b0, 1'b1, 26'h0010, 16'hA5A5, 1'b1, 1'b0, 16'h1111, 16'h0000};
        vecs[7]  = '{1'b1, 1'b1, 26'h0010, 16'hA5A5, 1'b1, 1'b0, 26'h0020, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b1, 26'h0010, 16'hA5A5, 1'b0, 1'b0, 16'h1111, 16'h0000};
        vecs[8]  = '{1'b0, 1'b0, 26'h0000, 16'h0000, 1'b1, 1'b0, 26'h0020, 16'h5555, 1'b0, 16'h0000, 1'b1, 1'b0, 26'h0020, 16'h5555, 1'b0, 1'b0, 16'h1111, 16'h0000};
        vecs[9]  = '{1'b0, 1'b0, 26'h0000, 16'h0000, 1'b1, 1'b0, 26'h0020, 16'h5555, 1'b1, 16'h2222, 1'b0, 1'b0, 26'h0020, 16'h5555, 1'b0, 1'b1, 16'h1111, 16'h2222};
        vecs[10] = '{1'b0, 1'b0, 26'h0000, 16'h0000, 1'b1, 1'b0, 26'h0020, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 26'h0020, 16'h5555, 1'b0, 1'b0, 16'h1111, 16'h2222};
        vecs[11] = '{1'b0, 1'b0, 26'h0000, 16'h0000, 1'b0, 1'b0, 26'h0000, 16'h0000, 1'b1, 16'h3333, 1'b0, 1'b0, 26'h0020, 16'h5555, 1'b0, 1'b0, 16'h1111, 16'h2222};
        vecs[12] = '{1'b1, 1'b0, 26'h0040, 16'h0000, 1'b0, 1'b0, 26'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 26'h0040, 16'h0000, 1'b0, 1'b0, 16'h1111, 16'h2222};
        vecs[13] = '{1'b0, 1'b0, 26'h0000, 16'h0000, 1'b0, 1'b0, 26'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 26'h0040, 16'h0000, 1'b0, 1'b0, 16'h1111, 16'h2222};
        vecs[14] = '{1'b0, 1'b0, 26'h0000, 16'h0000, 1'b0, 1'b0, 26'h0000, 16'h0000, 1'b1, 16'h4444, 1'b0, 1'b0, 26'h0040, 16'h0000, 1'b1, 1'b0, 16'h4444, 16'h2222};
        vecs[15] = '{1'b0, 1'b0, 26'h0000, 16'h0000, 1'b0, 1'b0, 26'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 26'h0040, 16'h0000, 1'b0, 1'b0, 16'h4444, 16'h2222};
        vecs[16] = '{1'b0, 1'b0, 26'h0000, 16'h0000, 1'b1, 1'b1, 26'h0100, 16'h0AAA, 1'b0, 16'h0000, 1'b1, 1'b1, 26'h0100, 16'h0AAA, 1'b0, 1'b0, 16'h4444, 16'h2222};
        vecs[17] = '{1'b0, 1'b0, 26'h0000, 16'h0000, 1'b1, 1'b1, 26'h0100, 16'h0AAA, 1'b1, 16'h7777, 1'b0, 1'b1, 26'h0100, 16'h0AAA, 1'b0, 1'b1, 16'h4444, 16'h7777};
        vecs[18] = '{1'b0, 1'b0, 26'h0000, 16'h0000, 1'b1, 1'b1, 26'h0101, 16'h0BBB, 1'b0, 16'h0000, 1'b0, 1'b1, 26'h0100, 16'h0AAA, 1'b0, 1'b0, 16'h4444, 16'h7777};
        vecs[19] = '{1'b0, 1'b0, 26'h0000, 16'h0000, 1'b1, 1'b1, 26'h0101, 16'h0BBB, 1'b0, 16'h0000, 1'b1, 1'b1, 26'h0101, 16'h0BBB, 1'b0, 1'b0, 16'h4444, 16'h7777};
        vecs[20] = '{1'b0, 1'b0, 26'h0000, 16'h0000, 1'b1, 1'b1, 26'h0101, 16'h0BBB, 1'b1, 16'h8888, 1'b0, 1'b1, 26'h0101, 16'h0BBB, 1'b0, 1'b1, 16'h4444, 16'h8888};
        vecs[21] = '{1'b0, 1'b0, 26'h0000, 16'h0000, 1'b0, 1'b0, 26'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 26'h0101, 16'h0BBB, 1'b0, 1'b0, 16'h4444, 16'h8888};

        // Reset state
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        reset_n = 1'b1;

        // Vector table: drive at negedge, check after the following posedge
        for (int i = 0; i < 22; i++) begin
            n64_req = vecs[i].n_req;  n64_write = vecs[i].n_wr;
            n64_address = vecs[i].n_addr; n64_wdata = vecs[i].n_wd;
            dma_req = vecs[i].d_req;  dma_write = vecs[i].d_wr;
            dma_address = vecs[i].d_addr; dma_wdata = vecs[i].d_wd;
            mem_ack = vecs[i].m_ack;  mem_rdata = vecs[i].m_rd;
            @(negedge clk);
            chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(vecs[i].e_wr));
            chk($sformatf("v%0d_mem_address", i), 32'(mem_address), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_wd));
            chk($sformatf("v%0d_n64_ack", i), 32'(n64_ack), 32'(vecs[i].e_nack));
            chk($sformatf("v%0d_dma_ack", i), 32'(dma_ack), 32'(vecs[i].e_dack));
            chk($sformatf("v%0d_n64_rdata", i), 32'(n64_rdata), 32'(vecs[i].e_nrd));
            chk($sformatf("v%0d_dma_rdata", i), 32'(dma_rdata), 32'(vecs[i].e_drd));
        end
        mem_ack = 1'b0;

        // Starvation: both requesters held high for 20 grants
        n64_req = 1'b1; n64_write = 1'b0; n64_address = 26'h10;
        dma_req = 1'b1; dma_write = 1'b0; dma_address = 26'h20;
        for (int k = 0; k < 20; k++) begin
            serve(16'(k), got);
`ifdef SDRAM_ARB_STARVE_GUARD_EN
            exp_addr = ((k % 5) == 4) ? 26'h20 : 26'h10;
`else
            exp_addr = 26'h10;
`endif
            chk($sformatf("starve_grant%0d", k), 32'(got), 32'(exp_addr));
        end
        n64_req = 1'b0; dma_req = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset during ACCESS
        n64_req = 1'b1; n64_write = 1'b1; n64_address = 26'h55; n64_wdata = 16'hC3C3;
        @(negedge clk);
        chk("rst_pre_mem_req", 32'(mem_req), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk_outputs_zero("async_rst");
        n64_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        ack_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (n64_ack || dma_ack || mem_req) ack_seen++;
        end
        chk("rst_no_replay", 32'(ack_seen), 32'd0);
        dma_req = 1'b1; dma_write = 1'b0; dma_address = 26'h77;
        @(negedge clk);
        chk("rst_fresh_mem_req", 32'(mem_req), 32'd1);
        chk("rst_fresh_addr", 32'(mem_address), 32'h77);
        mem_ack = 1'b1; mem_rdata = 16'h9999;
        @(negedge clk);
        mem_ack = 1'b0;
        dma_req = 1'b0;
        chk("rst_fresh_dma_ack", 32'(dma_ack), 32'd1);
        chk("rst_fresh_dma_rdata", 32'(dma_rdata), 32'h9999);
        chk("rst_fresh_n64_ack", 32'(n64_ack), 32'd0);
        @(negedge clk);
        chk("rst_fresh_ack_drop", 32'(dma_ack), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
